wb_burst_ram_slave: RTL
=======================

Name: wb_burst_ram_slave

Overview:
- Wishbone B4 slave: single-port on-chip RAM with registered acknowledge and CTI/BTE burst support.
- Sits directly downstream of the shared wishbone bus. Its port set matches one slot of the bus's s_*_o_all / s_*_i_all vectors; its cyc/stb come from that bus's one-hot strobe.
- Classic cycles have one wait state. Incrementing bursts sustain one beat per clock after the first, with linear or 4/8/16-beat wrap addressing.

Parameters:
- Dw, 32, data width; must equal 8*SELw.
- Aw, 10, word-address width; RAM depth is 2**Aw words.
- SELw, 4, byte-select width.
- TAGw, 3, tag width; the tag is accepted and ignored.
- CTIw, 3, cycle-type-identifier width.
- BTEw, 2, burst-type-extension width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- s_adr_i  in  Aw  word address; sampled only on the first beat of an access.
- s_dat_i  in  Dw  write data.
- s_sel_i  in  SELw  byte enables; bit i covers byte [8i+7:8i].
- s_tag_i  in  TAGw  unused.
- s_cti_i  in  CTIw  cycle type: 000 classic, 001 const, 010 increment, 111 end-of-burst.
- s_bte_i  in  BTEw  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- s_we_i  in  1  write enable.
- s_stb_i  in  1  strobe.
- s_cyc_i  in  1  cycle.
- s_dat_o  out  Dw  read data, valid when s_ack_o=1.
- s_ack_o  out  1  acknowledge.
- s_err_o  out  1  error.
- s_rty_o  out  1  retry; tied 0.

Behaviour:
- Reset:
  - Applied on the clock edge with reset==0, including mid-burst.
  - FSM goes to IDLE; the burst counter is cleared.
  - s_ack_o=0, s_err_o=0, s_rty_o=0, s_dat_o=0.
  - RAM contents are not cleared.
- Request: req = s_cyc_i & s_stb_i.
- FSM states: IDLE, CLASSIC_ACK, BURST, ERR.
- IDLE:
  - On req with cti in {000, 001, 111}: latch adr into cnt and go to CLASSIC_ACK. ack=1 in the following cycle (latency 1).
  - On req with cti=010: latch adr into cnt and go to BURST. The first ack is 1 cycle later.
  - On req with cti in {011..110}: go to ERR.
- CLASSIC_ACK:
  - ack=1 for exactly one cycle, then return to IDLE.
  - A held stb starts a new access, so back-to-back classic cycles give ack every 2nd cycle.
- BURST:
  - ack = req, combinational on the registered state; a beat completes in every cycle with ack=1.
  - Beat address is cnt. On each completed beat with cti != 111, cnt advances.
  - cnt advance, linear: cnt+1, wrapping modulo 2**Aw.
  - cnt advance, wrapN (N=4/8/16): the low log2(N) bits increment modulo N; the upper bits are held. Example: wrap4 from 0x006 gives 6,7,4,5.
  - A beat completing with cti=111 is the last beat: go to IDLE, and ack drops the next cycle.
  - stb=0 with cyc=1 is a master wait state: ack=0, cnt held, stay in BURST.
  - cyc=0 aborts the burst: go to IDLE with no further ack. Beats already written persist.
  - If s_bte_i changes mid-burst, the value sampled on the first beat is used.
- ERR:
  - err=1 for one cycle, ack=0, no RAM access, then return to IDLE.
  - ack and err are never both 1.
- Write:
  - On a beat with ack=1 and we=1, byte i of RAM[beat addr] is updated from s_dat_i when s_sel_i[i]=1.
  - The write commits at that clock edge.
- Read:
  - The RAM is a synchronous-read array.
  - The read address is the next beat address, presented one cycle ahead, so s_dat_o equals RAM[beat addr] in every ack cycle, including the first.
  - Read-after-write to the same address in consecutive beats returns the new data.
- s_dat_o:
  - Holds its last value when ack=0; it is 0 only after reset.
  - Write beats still drive the read value of RAM[beat addr] (pre-write contents).

Test Plan:
- Classic write then classic read:
  - Write adr 0x010, dat 0xDEADBEEF, sel 1111, cti 000: ack exactly 1 cycle after stb rises.
  - Read adr 0x010: s_dat_o = 0xDEADBEEF while ack=1.
- Byte enables:
  - Write 0xFFFFFFFF to 0x020, then write 0x11223344 with sel 0101.
  - Read of 0x020 returns 0xFF22FF44.
- Incrementing linear burst write, adr 0x3FE, cti 010,010,010,111, data 1..4:
  - ack on 4 consecutive cycles after the first.
  - RAM 0x3FE=1, 0x3FF=2, 0x000=3, 0x001=4 (address wrap).
- Wrap4 read burst from 0x006 (RAM preloaded with word addr as data):
  - s_dat_o sequence is 6,7,4,5.
  - ack drops the cycle after the cti=111 beat.
- Wait state and abort:
  - Burst from 0x040 with stb=0 for 2 cycles after beat 2: ack low, and beat 3 uses 0x042.
  - A second burst with cyc dropped after beat 2 leaves FSM in IDLE with no ack.
  - reset=0 mid-burst forces ack=0 and dat_o=0 on the next edge.
- Reserved cti=011: err=1 for one cycle, ack stays 0, RAM unchanged.

Source files
------------

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 RAM slave: synchronous-read on-chip RAM with one-wait-state classic
// cycles and single-cycle CTI/BTE incrementing bursts (linear or wrap4/8/16).
module wb_burst_ram_slave #(
    parameter int Dw   = 32,
    parameter int Aw   = 10,
    parameter int SELw = 4,
    parameter int TAGw = 3,
    parameter int CTIw = 3,
    parameter int BTEw = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Aw-1:0]   s_adr_i,
    input  logic [Dw-1:0]   s_dat_i,
    input  logic [SELw-1:0] s_sel_i,
    input  logic [TAGw-1:0] s_tag_i,
    input  logic [CTIw-1:0] s_cti_i,
    input  logic [BTEw-1:0] s_bte_i,
    input  logic            s_we_i,
    input  logic            s_stb_i,
    input  logic            s_cyc_i,
    output logic [Dw-1:0]   s_dat_o,
    output logic            s_ack_o,
    output logic            s_err_o,
    output logic            s_rty_o
);

    localparam logic [CTIw-1:0] CTI_CLASSIC = CTIw'(0);
    localparam logic [CTIw-1:0] CTI_CONST   = CTIw'(1);
    localparam logic [CTIw-1:0] CTI_INCR    = CTIw'(2);
    localparam logic [CTIw-1:0] CTI_EOB     = CTIw'(7);

    typedef enum logic [1:0] {IDLE, CLASSIC_ACK, BURST, ERR} state_t;

    state_t          state, state_nxt;
    logic [Aw-1:0]   cnt, cnt_nxt, cnt_inc, wrap_mask, rd_adr;
    logic [BTEw-1:0] bte_q, bte_nxt;
    logic [Dw-1:0]   rd_q, hold_q;
    logic            req, wr_en;
    logic [Dw-1:0]   mem [0:(1<<Aw)-1];

    logic unused_tag;
    assign unused_tag = ^s_tag_i;

    assign req     = s_cyc_i & s_stb_i;
    assign s_rty_o = 1'b0;
    assign wr_en   = s_ack_o & s_we_i;

    // Wrap bursts only advance the low bits selected by the mask.
    always_comb begin
        wrap_mask = '1;
        case (bte_q)
            BTEw'(1): wrap_mask = Aw'(3);
            BTEw'(2): wrap_mask = Aw'(7);
            BTEw'(3): wrap_mask = Aw'(15);
            default:  wrap_mask = '1;
        endcase
    end

    assign cnt_inc = (cnt & ~wrap_mask) | ((cnt + Aw'(1)) & wrap_mask);

    // rd_adr is the address of the next beat so the RAM output lines up with ack.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bte_nxt   = bte_q;
        rd_adr    = cnt;
        s_ack_o   = 1'b0;
        s_err_o   = 1'b0;
        case (state)
            IDLE: begin
                rd_adr = s_adr_i;
                if (req) begin
                    cnt_nxt = s_adr_i;
                    if (s_cti_i == CTI_INCR) begin
                        state_nxt = BURST;
                        bte_nxt   = s_bte_i;
                    end else if (s_cti_i == CTI_CLASSIC || s_cti_i == CTI_CONST ||
                                 s_cti_i == CTI_EOB) begin
                        state_nxt = CLASSIC_ACK;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            CLASSIC_ACK: begin
                s_ack_o   = 1'b1;
                state_nxt = IDLE;
            end
            BURST: begin
                s_ack_o = req;
                if (!s_cyc_i) begin
                    state_nxt = IDLE;
                end else if (req) begin
                    if (s_cti_i == CTI_EOB) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                        rd_adr  = cnt_inc;
                    end
                end
            end
            ERR: begin
                s_err_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bte_q  <= '0;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bte_q <= bte_nxt;
            if (s_ack_o)
                hold_q <= rd_q;
        end
    end

    // Byte-lane write; a read of the address being written forwards the new bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SELw; i++) begin
            if (wr_en && s_sel_i[i])
                mem[cnt][8*i +: 8] <= s_dat_i[8*i +: 8];
            if (wr_en && s_sel_i[i] && (cnt == rd_adr))
                rd_q[8*i +: 8] <= s_dat_i[8*i +: 8];
            else
                rd_q[8*i +: 8] <= mem[rd_adr][8*i +: 8];
        end
    end

    assign s_dat_o = s_ack_o ? rd_q : hold_q;

endmodule
